pe_packet_injector: RTL and testbench
=====================================

Name: pe_packet_injector

Overview:
- Clocked upstream feeder for the PPE array.
- Accepts row-level commands (one 5-weight filter row, or one 25-bit input-spike row), buffers them in a small FIFO, and serialises each command into the 33-bit PE packets the PPE consumes.
- Packet format: addr [32:29], opcode [28:25], data [24:0].
- Output uses a valid/ready handshake that the CSP bridge converts to the 4-phase bundled-data channel in front of the PPE.

Parameters:
- FIFO_DEPTH, 4, number of command entries buffered; power of two, at least 2.
- CNT_W, 16, width of the transferred-packet counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted on a rising edge where cmd_valid && cmd_ready.
- cmd_type  in  1  0 = weight row, 1 = input row.
- cmd_pe_id  in  4  destination PE address, copied to packet [32:29].
- cmd_data  in  40  weight row: w0..w4 in [7:0], [15:8], [23:16], [31:24], [39:32]; input row: spikes in [24:0], bits [39:25] ignored.
- out_valid  out  1  packet present on out_data.
- out_ready  in  1  downstream accepts; a transfer occurs on an edge where out_valid && out_ready.
- out_data  out  33  PE packet.
- busy  out  1  high when the FIFO is non-empty or out_valid is high.
- pkt_count  out  CNT_W  number of packets transferred; wraps.

Behaviour:
- Reset (async assert, synchronous release):
  - out_valid=0, out_data=0, pkt_count=0.
  - FSM=IDLE, FIFO empty.
  - cmd_ready=1 once rst_n is high; it is combinational !fifo_full.
- FIFO: write on cmd_valid && cmd_ready.
  - A write is blocked when full, even if a pop occurs in the same cycle.
  - Head entry is show-ahead (readable while non-empty).
  - Pop happens only when the FSM loads the last packet of a command.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, W_PKT0, W_PKT1, I_PKT. A state is "loaded" when its packet is on out_data with out_valid=1.
- IDLE:
  - FIFO empty: stay; out_valid=0.
  - Head is a weight row: go to W_PKT0 and load packet 0 (no pop).
  - Head is an input row: go to I_PKT, load the packet, and pop.
- W_PKT0 packet:
  - Fields: addr=pe_id, opcode=0, [24]=0, [23:16]=w2, [15:8]=w1, [7:0]=w0.
  - On transfer: go to W_PKT1 and load packet 1, then pop.
- W_PKT1 packet:
  - Fields: opcode=0, [24]=0, [23:16]=8'h00 (dummy), [15:8]=w4, [7:0]=w3.
- I_PKT packet: opcode=1, [24:0]=cmd_data[24:0].
- On transfer in W_PKT1 or I_PKT:
  - FIFO non-empty after the pop: load the next command's first packet on the same edge (zero bubble).
  - Otherwise go to IDLE and set out_valid=0.
- Handshake rules:
  - out_data and out_valid hold stable while out_valid && !out_ready.
  - out_valid never drops without a transfer.
- Latency:
  - A command accepted at edge N into an empty FIFO with the FSM in IDLE gives out_valid=1 after edge N+1.
  - Sustained throughput with out_ready=1: one packet per clock (weight row = 2 clocks, input row = 1 clock).
- pkt_count increments by 1 on each transfer and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-packet: the packet and all FIFO contents are discarded, and outputs return to their reset values immediately (asynchronously).

Decomposition:
- Package pe_pkt_pkg holds:
  - Field constants: PKT_W=33, ADDR_START=32, ADDR_END=29, OPCODE_START=28, OPCODE_END=25, DATA_START=24, DATA_END=0.
  - Opcodes: OP_WEIGHT=4'd0, OP_INPUT=4'd1.
  - Row constants: WEIGHTS_PER_ROW=5, WEIGHTS_PER_PKT=3, INPUTS_PER_ROW=25.
  - FSM state enum.
- One sub-module, pe_cmd_fifo: parameterised width/depth, show-ahead, async active-low reset, with full/empty flags. Entry = {type, pe_id, data} = 45 bits.

Test Plan:
- Weight row pe_id=5, w0..w4=1,2,3,4,5, out_ready=1 -> out_data 33'h0A0030201, then 33'h0A0000504 on consecutive clocks; pkt_count=2; busy drops afterwards.
- Input row pe_id=5, cmd_data[24:0]=25'h0AAAAAA -> single packet 33'h0A2AAAAAA, first out_valid one cycle after acceptance.
- out_ready held low for 5 cycles during W_PKT0 -> out_data stays 33'h0A0030201 with out_valid=1 throughout; packet 1 follows the first transfer.
- Push 5 commands with FIFO_DEPTH=4 and out_ready=0 -> cmd_ready low after 4 accepted (the FSM holds command 1 in place, so it has not been popped); after out_ready=1, all packets emerge in order with no bubbles.
- Assert rst_n low while W_PKT1 is stalled -> out_valid=0, pkt_count=0, FIFO empty immediately; after release, a fresh input row emits correctly.
- Force pkt_count to 16'hFFFF via 65535 transfers (or CNT_W=4 with 15 transfers) -> next transfer reads 0.

Source files
------------

// File: rtl/pe_pkt_pkg.sv
// Shared definitions for the PE packet injector.
// Provides:
//   - the PE packet field layout: addr [32:29], opcode [28:25], data [24:0]
//   - the opcodes and the row geometry constants
//   - the injector FSM state type and the buffered command entry layout
//   - helpers that build the two weight packets and the input packet payloads
package pe_pkt_pkg;

  localparam int PKT_W        = 33;
  localparam int ADDR_START   = 32;
  localparam int ADDR_END     = 29;
  localparam int OPCODE_START = 28;
  localparam int OPCODE_END   = 25;
  localparam int DATA_START   = 24;
  localparam int DATA_END     = 0;

  localparam logic [3:0] OP_WEIGHT = 4'd0;
  localparam logic [3:0] OP_INPUT  = 4'd1;

  localparam int WEIGHTS_PER_ROW = 5;
  localparam int WEIGHTS_PER_PKT = 3;
  localparam int INPUTS_PER_ROW  = 25;

  localparam int PE_ID_W    = 4;
  localparam int CMD_DATA_W = 8 * WEIGHTS_PER_ROW;
  localparam int CMD_W      = 1 + PE_ID_W + CMD_DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_W_PKT0,
    ST_W_PKT1,
    ST_I_PKT
  } inj_state_e;

  // One buffered command: {type, pe_id, data} = 45 bits.
  typedef struct packed {
    logic                  is_input;
    logic [PE_ID_W-1:0]    pe_id;
    logic [CMD_DATA_W-1:0] data;
  } cmd_t;

  function automatic logic [PKT_W-1:0] build_pkt(
    input logic [PE_ID_W-1:0]          addr,
    input logic [3:0]                  opcode,
    input logic [DATA_START:DATA_END]  payload
  );
    logic [PKT_W-1:0] pkt;
    pkt                            = '0;
    pkt[ADDR_START:ADDR_END]       = addr;
    pkt[OPCODE_START:OPCODE_END]   = opcode;
    pkt[DATA_START:DATA_END]       = payload;
    return pkt;
  endfunction

  // Packet 0 carries w0..w2; packet 1 carries w3..w4 with a zero dummy byte
  // in the third slot. Bit 24 is always zero for weight packets.
  function automatic logic [DATA_START:DATA_END] weight_payload(
    input logic [CMD_DATA_W-1:0] row,
    input logic                  second
  );
    logic [DATA_START:DATA_END] d;
    d = '0;
    if (!second) begin
      for (int k = 0; k < WEIGHTS_PER_PKT; k++) begin
        d[8*k +: 8] = row[8*k +: 8];
      end
    end else begin
      for (int k = 0; k < WEIGHTS_PER_ROW - WEIGHTS_PER_PKT; k++) begin
        d[8*k +: 8] = row[8*(k + WEIGHTS_PER_PKT) +: 8];
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/pe_cmd_fifo.sv
// Show-ahead command FIFO.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset (pointers only)
//   wr_en, wr_data    push request; ignored while full
//   rd_en             pop request; ignored while empty
//   rd_data           head entry, valid whenever empty is low
//   full, empty       occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without a separate occupancy counter.
module pe_cmd_fifo #(
  parameter int WIDTH = 45,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic             wr_fire;
  logic             rd_fire;

  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  // Full blocks a write even when a pop happens on the same edge.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;
  assign rd_data = mem_reg[rd_ptr_reg[AW-1:0]];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk) begin
        if (wr_fire && (wr_ptr_reg[AW-1:0] == AW'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_fire) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (rd_fire) rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
    end
  end

endmodule

// File: rtl/pe_packet_injector.sv
// Upstream feeder for the PPE array: buffers row commands and serialises
// each into 33-bit PE packets on a valid/ready output.
// Ports:
//   clk, rst_n                clock, asynchronous active-low reset
//   cmd_valid/cmd_ready       command handshake (cmd_ready = FIFO not full)
//   cmd_type                  0 = weight row (2 packets), 1 = input row (1 packet)
//   cmd_pe_id                 destination PE, placed in packet [32:29]
//   cmd_data                  five weights w0..w4 or 25 spike bits in [24:0]
//   out_valid/out_ready       packet handshake
//   out_data                  current packet
//   busy                      FIFO non-empty or a packet pending
//   pkt_count                 wrapping count of transferred packets
module pe_packet_injector
  import pe_pkt_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_type,
  input  logic [PE_ID_W-1:0]    cmd_pe_id,
  input  logic [CMD_DATA_W-1:0] cmd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PKT_W-1:0]      out_data,
  output logic                  busy,
  output logic [CNT_W-1:0]      pkt_count
);

  inj_state_e       state_reg, state_next;
  logic [PKT_W-1:0] out_data_reg, out_data_next;
  logic             out_valid_reg, out_valid_next;
  logic [CNT_W-1:0] pkt_count_reg;

  cmd_t             wr_entry;
  cmd_t             head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             pop;
  logic             load_head;
  logic             xfer;

  assign wr_entry = {cmd_type, cmd_pe_id, cmd_data};

  pe_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cmd_valid),
    .wr_data (wr_entry),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign cmd_ready = !fifo_full;
  assign xfer      = out_valid_reg && out_ready;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign pkt_count = pkt_count_reg;
  assign busy      = !fifo_empty || out_valid_reg;

  always_comb begin
    state_next     = state_reg;
    out_data_next  = out_data_reg;
    out_valid_next = out_valid_reg;
    pop            = 1'b0;
    load_head      = 1'b0;

    case (state_reg)
      ST_IDLE: begin
        load_head = !fifo_empty;
      end
      ST_W_PKT0: begin
        // The weight row stays at the head until its second packet is
        // loaded, so the pop is tied to that load.
        if (xfer) begin
          state_next    = ST_W_PKT1;
          out_data_next = build_pkt(head.pe_id, OP_WEIGHT, weight_payload(head.data, 1'b1));
          pop           = 1'b1;
        end
      end
      ST_W_PKT1, ST_I_PKT: begin
        // The current command was already popped; whatever is at the head
        // now is the next command and can be loaded without a bubble.
        if (xfer) begin
          if (!fifo_empty) begin
            load_head = 1'b1;
          end else begin
            state_next     = ST_IDLE;
            out_valid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next     = ST_IDLE;
        out_valid_next = 1'b0;
      end
    endcase

    if (load_head) begin
      out_valid_next = 1'b1;
      if (head.is_input) begin
        state_next    = ST_I_PKT;
        out_data_next = build_pkt(head.pe_id, OP_INPUT, head.data[INPUTS_PER_ROW-1:0]);
        pop           = 1'b1;
      end else begin
        state_next    = ST_W_PKT0;
        out_data_next = build_pkt(head.pe_id, OP_WEIGHT, weight_payload(head.data, 1'b0));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_IDLE;
      out_data_reg  <= '0;
      out_valid_reg <= 1'b0;
      pkt_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      out_data_reg  <= out_data_next;
      out_valid_reg <= out_valid_next;
      if (xfer) pkt_count_reg <= pkt_count_reg + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pe_packet_injector.sv
// Directed self-checking bench for pe_packet_injector (FIFO_DEPTH=4, CNT_W=4).
module tb_pe_packet_injector;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_type;
  logic [3:0]  cmd_pe_id;
  logic [39:0] cmd_data;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] out_data;
  logic        busy;
  logic [3:0]  pkt_count;

  int tests = 0;
  int fails = 0;

  logic [32:0] exp4 [9];
  bit          c5_taken;
  bit          accept;

  pe_packet_injector #(
    .FIFO_DEPTH (4),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_type  (cmd_type),
    .cmd_pe_id (cmd_pe_id),
    .cmd_data  (cmd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  // One line per packet transfer.
  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      $display("[TB] transfer pkt=%09h count_before=%0d", out_data, pkt_count);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic t, input logic [3:0] pe, input logic [39:0] d);
    cmd_valid = 1'b1;
    cmd_type  = t;
    cmd_pe_id = pe;
    cmd_data  = d;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    chk({tag, " idle timeout"}, busy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_type  = 1'b0;
    cmd_pe_id = 4'd0;
    cmd_data  = 40'd0;
    out_ready = 1'b0;

    // ---- reset state
    #1;
    chk("rst out_valid", out_valid, 1'b0);
    chk("rst out_data", out_data, 33'h0);
    chk("rst pkt_count", pkt_count, 4'd0);
    chk("rst busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post-rst cmd_ready", cmd_ready, 1'b1);
    chk("post-rst out_valid", out_valid, 1'b0);

    // ---- weight row pe 5, w0..w4 = 1..5, out_ready high
    out_ready = 1'b1;
    drive_cmd(1'b0, 4'd5, 40'h0504030201);
    tick();
    cmd_valid = 1'b0;
    chk("w accept out_valid", out_valid, 1'b0);
    chk("w accept busy", busy, 1'b1);
    tick();
    chk("w pkt0 valid", out_valid, 1'b1);
    chk("w pkt0 data", out_data, 33'h0A0030201);
    tick();
    chk("w pkt1 valid", out_valid, 1'b1);
    chk("w pkt1 data", out_data, 33'h0A0000504);
    chk("w count 1", pkt_count, 4'd1);
    tick();
    chk("w done valid", out_valid, 1'b0);
    chk("w count 2", pkt_count, 4'd2);
    chk("w done busy", busy, 1'b0);

    // ---- input row pe 5, spikes 0x0AAAAAA
    drive_cmd(1'b1, 4'd5, 40'h00000AAAAAA);
    tick();
    cmd_valid = 1'b0;
    chk("i accept out_valid", out_valid, 1'b0);
    tick();
    chk("i pkt valid", out_valid, 1'b1);
    chk("i pkt data", out_data, 33'h0A2AAAAAA);
    chk("i busy", busy, 1'b1);
    tick();
    chk("i done valid", out_valid, 1'b0);
    chk("i count 3", pkt_count, 4'd3);

    // ---- stall in W_PKT0 for 5 cycles
    out_ready = 1'b0;
    drive_cmd(1'b0, 4'd5, 40'h0504030201);
    tick();
    cmd_valid = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall%0d valid", k), out_valid, 1'b1);
      chk($sformatf("stall%0d data", k), out_data, 33'h0A0030201);
      tick();
    end
    chk("stall count held", pkt_count, 4'd3);
    out_ready = 1'b1;
    tick();
    chk("stall pkt1 data", out_data, 33'h0A0000504);
    chk("stall pkt1 valid", out_valid, 1'b1);
    tick();
    chk("stall done valid", out_valid, 1'b0);
    chk("stall count 5", pkt_count, 4'd5);

    // ---- fill FIFO with 5 commands while out_ready is low
    exp4[0] = 33'h020131211;
    exp4[1] = 33'h020001514;
    exp4[2] = 33'h040232221;
    exp4[3] = 33'h040002524;
    exp4[4] = 33'h060333231;
    exp4[5] = 33'h060003534;
    exp4[6] = 33'h080434241;
    exp4[7] = 33'h080004544;
    exp4[8] = 33'h0C3234567;
    out_ready = 1'b0;
    chk("fill c1 ready", cmd_ready, 1'b1);
    drive_cmd(1'b0, 4'd1, 40'h1514131211);
    tick();
    chk("fill c2 ready", cmd_ready, 1'b1);
    drive_cmd(1'b0, 4'd2, 40'h2524232221);
    tick();
    chk("fill c3 ready", cmd_ready, 1'b1);
    drive_cmd(1'b0, 4'd3, 40'h3534333231);
    tick();
    chk("fill c4 ready", cmd_ready, 1'b1);
    drive_cmd(1'b0, 4'd4, 40'h4544434241);
    tick();
    chk("fill full ready", cmd_ready, 1'b0);
    drive_cmd(1'b1, 4'd6, {15'h7FFF, 25'h1234567});
    tick();
    chk("fill still full", cmd_ready, 1'b0);
    c5_taken  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      chk($sformatf("burst%0d valid", k), out_valid, 1'b1);
      chk($sformatf("burst%0d data", k), out_data, exp4[k]);
      accept = cmd_valid && cmd_ready;
      tick();
      if (accept) begin
        cmd_valid = 1'b0;
        c5_taken  = 1'b1;
      end
    end
    chk("burst c5 accepted", c5_taken, 1'b1);
    chk("burst done valid", out_valid, 1'b0);
    chk("burst done busy", busy, 1'b0);
    chk("burst count 14", pkt_count, 4'd14);

    // ---- reset while W_PKT1 is stalled, with another command queued
    drive_cmd(1'b0, 4'd7, 40'h7574737271);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rw pkt0 data", out_data, 33'h0E0737271);
    tick();
    out_ready = 1'b0;
    chk("rw pkt1 data", out_data, 33'h0E0007574);
    drive_cmd(1'b1, 4'd2, 40'h0000000001);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("rw stalled valid", out_valid, 1'b1);
    chk("rw stalled data", out_data, 33'h0E0007574);
    chk("rw count 15", pkt_count, 4'd15);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async rst valid", out_valid, 1'b0);
    chk("async rst data", out_data, 33'h0);
    chk("async rst count", pkt_count, 4'd0);
    chk("async rst busy", busy, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("after rst valid", out_valid, 1'b0);
    chk("after rst busy", busy, 1'b0);
    out_ready = 1'b1;
    drive_cmd(1'b1, 4'd5, 40'h0001555555);
    tick();
    cmd_valid = 1'b0;
    chk("fresh accept valid", out_valid, 1'b0);
    tick();
    chk("fresh pkt valid", out_valid, 1'b1);
    chk("fresh pkt data", out_data, 33'h0A3555555);
    tick();
    chk("fresh done valid", out_valid, 1'b0);
    chk("fresh count 1", pkt_count, 4'd1);

    // ---- counter wrap: 14 more transfers reach 15, one more wraps to 0
    for (int i = 0; i < 14; i++) begin
      drive_cmd(1'b1, 4'd3, 40'(i));
      tick();
    end
    cmd_valid = 1'b0;
    wait_idle("wrap fill");
    chk("wrap count 15", pkt_count, 4'd15);
    drive_cmd(1'b1, 4'd3, 40'h0000000009);
    tick();
    cmd_valid = 1'b0;
    tick();
    chk("wrap last data", out_data, 33'h062000009);
    tick();
    chk("wrap count 0", pkt_count, 4'd0);
    chk("wrap done valid", out_valid, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
